time_adjust_ctrl: RTL and testbench
===================================

TIME_ADJUST_CTRL -- requirements
Module: time_adjust_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 50, meaning ticks a held up/down button waits before auto-repeat starts (legal range 1..255).
REQ-002 SHALL have parameter REPEAT_PERIOD, default 10, meaning ticks between auto-repeat pulses (legal range 1..255).
REQ-003 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tick  input  1  one-clk timebase strobe (e.g. 100 Hz) used only by the repeat timer.
REQ-006 SHALL have ports btn_c, btn_l, btn_r, btn_u, btn_d  input  1 each  debounced, synchronized button levels (1 = pressed).
REQ-007 SHALL have port mode  output  2  0 = CLOCK, 1 = SET_TIME, 2 = SET_ALARM; value 3 is never driven.
REQ-008 SHALL have port field_sel  output  1  0 = minutes, 1 = hours.
REQ-009 SHALL have ports tm_min_up, tm_min_dn, tm_hr_up, tm_hr_dn  output  1 each  one-clk step pulses to the time counters.
REQ-010 SHALL have ports al_min_up, al_min_dn, al_hr_up, al_hr_dn  output  1 each  one-clk step pulses to the alarm counters.
REQ-011 SHALL have port clock_en  output  1  run enable for the timekeeping counters.

Function
REQ-012 SHALL register each button every clk and define press = current sample high AND previous sample low.
REQ-013 SHALL advance mode on a btn_c press: CLOCK -> SET_TIME -> SET_ALARM -> CLOCK.
REQ-014 SHALL force field_sel to 0 on every mode change and hold it at 0 in CLOCK.
REQ-015 SHALL, in SET modes only, set field_sel to 1 on a btn_l press and to 0 on a btn_r press; simultaneous l and r presses are ignored.
REQ-016 SHALL, in SET modes, on a btn_u or btn_d press emit exactly one pulse on the output selected by mode (tm_* in SET_TIME, al_* in SET_ALARM), field_sel (min/hr) and direction (up/dn).
REQ-017 SHALL register all pulse outputs: the pulse is high for the single clk after the edge at which the press is detected.
REQ-018 SHALL never assert more than one of the eight pulse outputs in any cycle.
REQ-019 SHALL ignore l, r, u and d in CLOCK mode: no pulse is emitted and field_sel does not change.
REQ-020 SHALL give btn_c priority: in a cycle with a btn_c press, no pulse is emitted and any l/r press is discarded.
REQ-021 SHALL treat btn_u and btn_d both high as "no hold": no pulse is emitted, and repeat state is cleared for as long as both are high.
REQ-022 SHALL implement an auto-repeat FSM with states IDLE, WAIT and REPEAT and an 8-bit tick counter.
REQ-023 SHALL clear the repeat counter and move from IDLE to WAIT on a valid up/down press.
REQ-024 SHALL, in WAIT or REPEAT, increment the repeat counter on each tick while the same single button remains held.
REQ-025 SHALL, in WAIT, when the counter reaches REPEAT_DELAY, emit one pulse, clear the counter and enter REPEAT.
REQ-026 SHALL, in REPEAT, emit one pulse and clear the counter each time the counter reaches REPEAT_PERIOD.
REQ-027 SHALL return to IDLE and clear the counter on release of the held button, on a mode change, on a field_sel change, or on both u and d high.
REQ-028 SHALL drive clock_en = 0 in SET_TIME and 1 in CLOCK and SET_ALARM.

Reset
REQ-029 SHALL, on reset, set mode = CLOCK, field_sel = 0, all pulse outputs = 0, clock_en = 1, the repeat FSM to IDLE and the counter to 0.
REQ-030 SHALL load the button history registers with all ones on reset, so a button held through reset produces no press.
REQ-031 SHALL let reset override all other inputs in the same cycle, including mid-repeat.

Verification
REQ-032 SHALL cover: after reset, btn_c press -> mode = 1, clock_en = 0; second press -> mode = 2, clock_en = 1; third press -> mode = 0.
REQ-033 SHALL cover: in SET_TIME, btn_l press then btn_u tap -> exactly one tm_hr_up pulse, 1 clk wide, 1 clk after press detection.
REQ-034 SHALL cover: in SET_ALARM with btn_d held for 100 ticks, defaults -> pulses on al_min_dn at press, at tick 50, then at ticks 60, 70, 80, 90 and 100 (7 total).
REQ-035 SHALL cover: btn_u and btn_d pressed together, or btn_u pressed in CLOCK mode -> no pulse output asserted.
REQ-036 SHALL cover: btn_u held through reset deassertion -> no pulse; reset asserted mid-REPEAT -> all outputs return to their reset values the next clk.
REQ-037 SHALL cover: btn_c and btn_u pressed in the same cycle in SET_TIME -> mode = 2 and no pulse is emitted.

Source files
------------

// File: rtl/time_adjust_ctrl.sv
// Button front end for clock/alarm setting: mode cycling, min/hr field selection
// and single-step plus auto-repeat step pulses towards the time and alarm counters.
module time_adjust_ctrl #(
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    output logic [1:0] mode,
    output logic       field_sel,
    output logic       tm_min_up,
    output logic       tm_min_dn,
    output logic       tm_hr_up,
    output logic       tm_hr_dn,
    output logic       al_min_up,
    output logic       al_min_dn,
    output logic       al_hr_up,
    output logic       al_hr_dn,
    output logic       clock_en
);

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_WAIT   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam logic [7:0] DELAY_TICKS  = 8'(REPEAT_DELAY);
    localparam logic [7:0] PERIOD_TICKS = 8'(REPEAT_PERIOD);

    mode_t      mode_q;
    rpt_state_t rpt_state;
    logic [7:0] rpt_cnt;
    logic [7:0] cnt_inc;
    logic       held_up;
    logic [7:0] pulse_q;

    logic [4:0] btn_now;
    logic [4:0] btn_prev;
    logic [4:0] press;
    logic       press_c;
    logic       press_l;
    logic       press_r;
    logic       press_u;
    logic       press_d;
    logic       both_ud;
    logic       field_change;
    logic       held_level;
    logic       step_up;
    logic [2:0] pulse_idx;

    assign btn_now = {btn_c, btn_l, btn_r, btn_u, btn_d};
    assign press   = btn_now & ~btn_prev;
    assign press_c = press[4];
    assign press_l = press[3];
    assign press_r = press[2];
    assign press_u = press[1];
    assign press_d = press[0];

    assign both_ud      = btn_u & btn_d;
    assign field_change = (press_l ^ press_r) & (press_l ^ field_sel);
    assign held_level   = held_up ? btn_u : btn_d;
    assign cnt_inc      = rpt_cnt + 8'd1;

    // A fresh press picks its own direction; repeat steps reuse the held one.
    assign step_up   = (press_u | press_d) ? press_u : held_up;
    assign pulse_idx = {mode_q == MODE_SET_ALARM, field_sel, ~step_up};

    assign mode      = mode_q;
    assign clock_en  = (mode_q != MODE_SET_TIME);
    assign tm_min_up = pulse_q[0];
    assign tm_min_dn = pulse_q[1];
    assign tm_hr_up  = pulse_q[2];
    assign tm_hr_dn  = pulse_q[3];
    assign al_min_up = pulse_q[4];
    assign al_min_dn = pulse_q[5];
    assign al_hr_up  = pulse_q[6];
    assign al_hr_dn  = pulse_q[7];

    // Priority: reset, then btn_c, then CLOCK-mode lockout, then SET-mode editing.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev  <= '1;
            mode_q    <= MODE_CLOCK;
            field_sel <= 1'b0;
            pulse_q   <= '0;
            rpt_state <= RPT_IDLE;
            rpt_cnt   <= '0;
            held_up   <= 1'b0;
        end else begin
            btn_prev <= btn_now;
            pulse_q  <= '0;
            if (press_c) begin
                case (mode_q)
                    MODE_CLOCK:    mode_q <= MODE_SET_TIME;
                    MODE_SET_TIME: mode_q <= MODE_SET_ALARM;
                    default:       mode_q <= MODE_CLOCK;
                endcase
                field_sel <= 1'b0;
                rpt_state <= RPT_IDLE;
                rpt_cnt   <= '0;
            end else if (mode_q != MODE_CLOCK) begin
                if (field_change) begin
                    field_sel <= press_l;
                end
                if (both_ud) begin
                    rpt_state <= RPT_IDLE;
                    rpt_cnt   <= '0;
                end else if (press_u || press_d) begin
                    // A step taken together with a field switch does not arm repeat.
                    pulse_q[pulse_idx] <= 1'b1;
                    held_up   <= press_u;
                    rpt_cnt   <= '0;
                    rpt_state <= field_change ? RPT_IDLE : RPT_WAIT;
                end else if (field_change) begin
                    rpt_state <= RPT_IDLE;
                    rpt_cnt   <= '0;
                end else if (rpt_state != RPT_IDLE) begin
                    if (!held_level) begin
                        rpt_state <= RPT_IDLE;
                        rpt_cnt   <= '0;
                    end else if (tick) begin
                        if (rpt_state == RPT_WAIT && cnt_inc == DELAY_TICKS) begin
                            pulse_q[pulse_idx] <= 1'b1;
                            rpt_cnt   <= '0;
                            rpt_state <= RPT_REPEAT;
                        end else if (rpt_state == RPT_REPEAT && cnt_inc == PERIOD_TICKS) begin
                            pulse_q[pulse_idx] <= 1'b1;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= cnt_inc;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Directed scenarios plus randomized button traffic for time_adjust_ctrl, checked
// every cycle against a countdown-based behavioural model of the adjust rules.
module tb_time_adjust_ctrl;

    localparam int DELAY  = 50;
    localparam int PERIOD = 10;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] C    = 5'b10000;
    localparam logic [4:0] L    = 5'b01000;
    localparam logic [4:0] U    = 5'b00010;
    localparam logic [4:0] D    = 5'b00001;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       btn_c, btn_l, btn_r, btn_u, btn_d;
    logic [1:0] mode;
    logic       field_sel;
    logic       tm_min_up, tm_min_dn, tm_hr_up, tm_hr_dn;
    logic       al_min_up, al_min_dn, al_hr_up, al_hr_dn;
    logic       clock_en;

    time_adjust_ctrl #(.REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .mode(mode), .field_sel(field_sel),
        .tm_min_up(tm_min_up), .tm_min_dn(tm_min_dn), .tm_hr_up(tm_hr_up), .tm_hr_dn(tm_hr_dn),
        .al_min_up(al_min_up), .al_min_dn(al_min_dn), .al_hr_up(al_hr_up), .al_hr_dn(al_hr_dn),
        .clock_en(clock_en)
    );

    always #5 clk = ~clk;

    int numChecks = 0;
    int numPassed = 0;

    // Reference model: buttons, mode, field, and a countdown to the next repeat step.
    logic [4:0] mPrev;
    int         mMode;
    logic       mField;
    bit         mHolding;
    bit         mHoldUp;
    int         mLeft;
    logic [7:0] mPulse;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        numChecks++;
        if (actual === expected) numPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    function automatic logic [7:0] dutPulses();
        return {al_hr_dn, al_hr_up, al_min_dn, al_min_up, tm_hr_dn, tm_hr_up, tm_min_dn, tm_min_up};
    endfunction

    function automatic logic [7:0] stepMask(int modeV, logic fieldV, bit up);
        int bitPos;
        bitPos = (modeV == 2 ? 4 : 0) + (fieldV ? 2 : 0) + (up ? 0 : 1);
        return 8'(1 << bitPos);
    endfunction

    task automatic modelStep(input logic [4:0] b, input logic t, input logic r);
        logic [4:0] p;
        bit pc, pl, pr, pu, pd, u, d, fc;
        p  = b & ~mPrev;
        pc = p[4]; pl = p[3]; pr = p[2]; pu = p[1]; pd = p[0];
        u  = b[1]; d = b[0];
        mPulse = 8'h00;
        if (r) begin
            mPrev = 5'b11111; mMode = 0; mField = 1'b0; mHolding = 0; mLeft = 0;
            return;
        end
        mPrev = b;
        if (pc) begin
            mMode    = (mMode + 1) % 3;
            mField   = 1'b0;
            mHolding = 0;
        end else if (mMode != 0) begin
            fc = (pl != pr) && (pl != mField);
            if (u && d) begin
                mHolding = 0;
            end else if (pu || pd) begin
                mPulse   = stepMask(mMode, mField, pu);
                mHolding = !fc;
                mHoldUp  = pu;
                mLeft    = DELAY;
            end else if (fc) begin
                mHolding = 0;
            end else if (mHolding) begin
                if (!(mHoldUp ? u : d)) begin
                    mHolding = 0;
                end else if (t) begin
                    mLeft--;
                    if (mLeft == 0) begin
                        mPulse = stepMask(mMode, mField, mHoldUp);
                        mLeft  = PERIOD;
                    end
                end
            end
            if (fc) mField = pl;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic [4:0] b, input logic t, input logic r);
        {btn_c, btn_l, btn_r, btn_u, btn_d} = b;
        tick  = t;
        reset = r;
        modelStep(b, t, r);
        @(posedge clk);
        #1;
        checkOutput("cycle", {4'd0, mode, field_sel, clock_en, dutPulses()},
                    {4'd0, 2'(mMode), mField, (mMode != 1), mPulse});
    endtask

    initial begin
        int cnt;
        int alCnt;
        int otherCnt;
        logic [4:0] lv;
        logic t, r;

        reset = 1'b1; tick = 1'b0;
        {btn_c, btn_l, btn_r, btn_u, btn_d} = NONE;
        mPrev = 5'b11111; mMode = 0; mField = 1'b0; mHolding = 0; mHoldUp = 0; mLeft = 0; mPulse = 8'h00;
        @(posedge clk);
        #1;

        // Reset with btn_u held, then release reset while still holding it.
        applyStimulus(U, 1'b0, 1'b1);
        applyStimulus(U, 1'b1, 1'b1);
        checkOutput("reset_mode", 16'(mode), 16'd0);
        checkOutput("reset_field", 16'(field_sel), 16'd0);
        checkOutput("reset_clock_en", 16'(clock_en), 16'd1);
        checkOutput("reset_pulses", 16'(dutPulses()), 16'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(U, 1'(i % 2), 1'b0);
            cnt += $countones(dutPulses());
        end
        checkOutput("held_thru_reset", 16'(cnt), 16'd0);
        applyStimulus(NONE, 1'b0, 1'b0);

        // Mode cycling
        applyStimulus(C, 1'b0, 1'b0);
        checkOutput("mode_set_time", 16'(mode), 16'd1);
        checkOutput("clock_en_set_time", 16'(clock_en), 16'd0);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(C, 1'b0, 1'b0);
        checkOutput("mode_set_alarm", 16'(mode), 16'd2);
        checkOutput("clock_en_set_alarm", 16'(clock_en), 16'd1);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(C, 1'b0, 1'b0);
        checkOutput("mode_clock", 16'(mode), 16'd0);
        applyStimulus(NONE, 1'b0, 1'b0);

        // SET_TIME: select hours, tap up
        applyStimulus(C, 1'b0, 1'b0);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(L, 1'b0, 1'b0);
        checkOutput("field_hours", 16'(field_sel), 16'd1);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(U, 1'b0, 1'b0);
        checkOutput("tm_hr_up_pulse", 16'(dutPulses()), 16'h0004);
        applyStimulus(NONE, 1'b0, 1'b0);
        checkOutput("tm_hr_up_width", 16'(dutPulses()), 16'h0000);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(NONE, 1'b1, 1'b0);
            cnt += $countones(dutPulses());
        end
        checkOutput("tm_hr_up_single", 16'(cnt), 16'd0);

        // btn_c and btn_u together in SET_TIME
        applyStimulus(C | U, 1'b0, 1'b0);
        checkOutput("c_priority_mode", 16'(mode), 16'd2);
        checkOutput("c_priority_pulse", 16'(dutPulses()), 16'h0000);
        applyStimulus(NONE, 1'b0, 1'b0);

        // Up and down together, then up in CLOCK mode
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            applyStimulus(U | D, 1'(i % 2), 1'b0);
            cnt += $countones(dutPulses());
        end
        checkOutput("ud_together", 16'(cnt), 16'd0);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(C, 1'b0, 1'b0);
        applyStimulus(NONE, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            applyStimulus(U, 1'(i % 2), 1'b0);
            cnt += $countones(dutPulses());
        end
        checkOutput("clock_mode_u", 16'(cnt), 16'd0);
        checkOutput("clock_mode_field", 16'(field_sel), 16'd0);
        applyStimulus(NONE, 1'b0, 1'b0);

        // SET_ALARM: hold down for 100 ticks
        applyStimulus(C, 1'b0, 1'b0);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(C, 1'b0, 1'b0);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(D, 1'b0, 1'b0);
        checkOutput("al_min_dn_press", 16'(dutPulses()), 16'h0020);
        alCnt = 1;
        otherCnt = 0;
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(D, 1'b1, 1'b0);
            alCnt += int'(al_min_dn);
            otherCnt += $countones(dutPulses()) - int'(al_min_dn);
            applyStimulus(D, 1'b0, 1'b0);
            alCnt += int'(al_min_dn);
            otherCnt += $countones(dutPulses()) - int'(al_min_dn);
            if (k == 49) checkOutput("repeat_before_delay", 16'(alCnt), 16'd1);
            if (k == 50) checkOutput("repeat_at_delay", 16'(alCnt), 16'd2);
            if (k == 59) checkOutput("repeat_before_period", 16'(alCnt), 16'd2);
            if (k == 60) checkOutput("repeat_at_period", 16'(alCnt), 16'd3);
        end
        checkOutput("repeat_total", 16'(alCnt), 16'd7);
        checkOutput("repeat_other_pulses", 16'(otherCnt), 16'd0);
        applyStimulus(NONE, 1'b0, 1'b0);

        // Reset in the middle of an auto-repeat run in SET_TIME hours
        applyStimulus(C, 1'b0, 1'b0);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(C, 1'b0, 1'b0);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(L, 1'b0, 1'b0);
        applyStimulus(NONE, 1'b0, 1'b0);
        applyStimulus(U, 1'b0, 1'b0);
        for (int k = 0; k < 69; k++) begin
            applyStimulus(U, 1'b1, 1'b0);
            applyStimulus(U, 1'b0, 1'b0);
        end
        applyStimulus(U, 1'b1, 1'b1);
        checkOutput("midrpt_reset_mode", 16'(mode), 16'd0);
        checkOutput("midrpt_reset_field", 16'(field_sel), 16'd0);
        checkOutput("midrpt_reset_clock_en", 16'(clock_en), 16'd1);
        checkOutput("midrpt_reset_pulses", 16'(dutPulses()), 16'h0000);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(U, 1'b1, 1'b0);
            cnt += $countones(dutPulses());
        end
        checkOutput("midrpt_after_reset", 16'(cnt), 16'd0);
        applyStimulus(NONE, 1'b0, 1'b0);

        // Randomized button traffic against the model
        lv = NONE;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) lv[4] = ~lv[4];
            if ($urandom_range(0, 79) == 0)  lv[3] = ~lv[3];
            if ($urandom_range(0, 79) == 0)  lv[2] = ~lv[2];
            if ($urandom_range(0, 119) == 0) lv[1] = ~lv[1];
            if ($urandom_range(0, 119) == 0) lv[0] = ~lv[0];
            t = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 999) == 0);
            applyStimulus(lv, t, r);
        end

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
